dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Byte-addressed data memory behind a request/response handshake with WAIT_CYCLES wait states.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned H/W accesses with rsp_err instead of splitting them.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [7:0]  mem [DEPTH];

    logic        a_we;
    logic [2:0]  a_f3;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;

    // With no wait states the access happens on the acceptance edge, so it must see the live request.
    generate
        if (WAIT_CYCLES == 0) begin : g_direct
            assign a_we    = req_we;
            assign a_f3    = req_funct3;
            assign a_addr  = req_addr;
            assign a_wdata = req_wdata;
        end else begin : g_captured
            assign a_we    = we_q;
            assign a_f3    = f3_q;
            assign a_addr  = addr_q;
            assign a_wdata = wdata_q;
        end
    endgenerate

    logic [2:0]  size_m1;
    logic        f3_ok;
    logic        misalign;
    logic [32:0] last_addr;
    logic        range_err;
    logic        a_err;

    always_comb begin
        size_m1 = 3'd0;
        f3_ok   = 1'b1;
        case (a_f3)
            3'b000, 3'b100: size_m1 = 3'd0;
            3'b001, 3'b101: size_m1 = 3'd1;
            3'b010:         size_m1 = 3'd3;
            default:        f3_ok   = 1'b0;
        endcase
        if (a_we && a_f3[2]) begin
            f3_ok = 1'b0;
        end
    end

    assign last_addr = {1'b0, a_addr} + {30'd0, size_m1};
    assign range_err = last_addr >= 33'(DEPTH);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
                      ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign a_err = !f3_ok || range_err || misalign;

    logic [AW-1:0] idx [4];
    logic [7:0]    rb  [4];
    logic [31:0]   ld_data;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idx[i] = a_addr[AW-1:0] + AW'(i);
            rb[i]  = mem[idx[i]];
        end
        ld_data = 32'd0;
        case (a_f3)
            3'b000:  ld_data = {{24{rb[0][7]}}, rb[0]};
            3'b100:  ld_data = {24'd0, rb[0]};
            3'b001:  ld_data = {{16{rb[1][7]}}, rb[1], rb[0]};
            3'b101:  ld_data = {16'd0, rb[1], rb[0]};
            3'b010:  ld_data = {rb[3], rb[2], rb[1], rb[0]};
            default: ld_data = 32'd0;
        endcase
        if (a_we || a_err) begin
            ld_data = 32'd0;
        end
    end

    logic access_fire;
    logic mem_we;

    assign access_fire = ((WAIT_CYCLES == 0) && (state_q == IDLE) && req_valid) ||
                         ((state_q == WAIT) && (cnt_q == 4'd0));
    assign mem_we      = access_fire && a_we && !a_err && !reset;

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) <= size_m1) begin
                    mem[idx[i]] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        f3_q        <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= ld_data;
                            rsp_err_q   <= a_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ld_data;
                        rsp_err_q   <= a_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
